// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges unbuffered ALU results and FIFO-queued load results
// into a single registered register-file write per cycle, with a starvation guard.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_WIDTH-1:0]       alu_rd,
  input  logic [WORD_WIDTH-1:0]       alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_WIDTH-1:0]       ld_rd,
  input  logic [WORD_WIDTH-1:0]       ld_data,
  output logic                        rf_we,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [WORD_WIDTH-1:0]       rf_wdata,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [ADDR_WIDTH-1:0] lq_rd   [LQ_DEPTH];
  logic [WORD_WIDTH-1:0] lq_data [LQ_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [SW-1:0]         starve;
  logic                  lq_nonempty;
  logic                  force_ld;
  logic                  alu_win;
  logic                  ld_win;
  logic                  push;

  // A queued load that has lost STARVE_MAX times in a row blocks the ALU for one cycle.
  assign lq_nonempty = (lq_count != '0);
  assign force_ld    = lq_nonempty && (starve == SW'(STARVE_MAX));
  assign alu_ready   = rst_n && !force_ld;
  assign ld_ready    = rst_n && (lq_count < CW'(LQ_DEPTH));
  assign alu_win     = alu_valid && alu_ready;
  assign ld_win      = lq_nonempty && !alu_win;
  assign push        = ld_valid && ld_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr]   <= ld_rd;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  // Pointers wrap naturally because LQ_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (ld_win)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, ld_win})
        2'b10:   lq_count <= lq_count + 1'b1;
        2'b01:   lq_count <= lq_count - 1'b1;
        default: lq_count <= lq_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else if (!lq_nonempty || ld_win)
      starve <= '0;
    else if (starve != SW'(STARVE_MAX))
      starve <= starve + 1'b1;
  end

  // Writes to x0 still consume the winner but never raise rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (alu_win) begin
      rf_we    <= (alu_rd != '0);
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else if (ld_win) begin
      rf_we    <= (lq_rd[rd_ptr] != '0);
      rf_waddr <= lq_rd[rd_ptr];
      rf_wdata <= lq_data[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model and a write scoreboard.
module tb_wb_arbiter;

  localparam int AW         = 5;
  localparam int WW         = 32;
  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 4;
  localparam int CW         = $clog2(LQ_DEPTH) + 1;

  typedef struct {
    logic [AW-1:0] rd;
    logic [WW-1:0] data;
    int            acc;
  } ld_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, ld_valid, ld_ready, rf_we;
  logic [AW-1:0] alu_rd, ld_rd, rf_waddr;
  logic [WW-1:0] alu_data, ld_data, rf_wdata;
  logic [CW-1:0] lq_count;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  ld_t           mq[$];
  ld_t           sb_ld[$];
  ld_t           sb_alu[$];
  int            m_loss;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [WW-1:0] m_wdata;

  wb_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .lq_count(lq_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [WW-1:0] adat,
                               input logic lv, input logic [AW-1:0] lrd, input logic [WW-1:0] ldat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678);
    #1;
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL rst_we: got %0b expected 0", rf_we); else passes++;
    checks++; if (rf_waddr !== 5'd0) $display("[TB] FAIL rst_waddr: got %0d expected 0", rf_waddr); else passes++;
    checks++; if (rf_wdata !== 32'd0) $display("[TB] FAIL rst_wdata: got %h expected 0", rf_wdata); else passes++;
    checks++; if (lq_count !== 2'd0) $display("[TB] FAIL rst_count: got %0d expected 0", lq_count); else passes++;
    checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL rst_alu_ready: got %0b expected 0", alu_ready); else passes++;
    checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL rst_ld_ready: got %0b expected 0", ld_ready); else passes++;
    @(negedge clk);
    checks++; if (lq_count !== 2'd0) $display("[TB] FAIL rst_no_push: got %0d expected 0", lq_count); else passes++;
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL rst_no_write: got %0b expected 0", rf_we); else passes++;
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL rst_release_we: got %0b expected 0", rf_we); else passes++;
  endtask

  task automatic test_alu();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    #1;
    checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL alu_ready: got %0b expected 1", alu_ready); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) $display("[TB] FAIL alu_we: got %0b expected 1", rf_we); else passes++;
    checks++; if (rf_waddr !== 5'd5) $display("[TB] FAIL alu_waddr: got %0d expected 5", rf_waddr); else passes++;
    checks++; if (rf_wdata !== 32'hDEADBEEF) $display("[TB] FAIL alu_wdata: got %h expected deadbeef", rf_wdata); else passes++;
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL alu_we_drop: got %0b expected 0", rf_we); else passes++;
    checks++; if (rf_wdata !== 32'hDEADBEEF) $display("[TB] FAIL alu_hold: got %h expected deadbeef", rf_wdata); else passes++;
  endtask

  task automatic test_loads();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd1, 32'h11);
    #1;
    checks++; if (ld_ready !== 1'b1) $display("[TB] FAIL ld_ready0: got %0b expected 1", ld_ready); else passes++;
    @(negedge clk);
    checks++; if (lq_count !== 2'd1) $display("[TB] FAIL ld_count1: got %0d expected 1", lq_count); else passes++;
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL ld_early_we: got %0b expected 0", rf_we); else passes++;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd2, 32'h22);
    @(negedge clk);
    idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11)
      $display("[TB] FAIL ld_first: got we=%0b rd=%0d data=%h expected 1/1/11", rf_we, rf_waddr, rf_wdata); else passes++;
    checks++; if (lq_count !== 2'd1) $display("[TB] FAIL ld_count_pushpop: got %0d expected 1", lq_count); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22)
      $display("[TB] FAIL ld_second: got we=%0b rd=%0d data=%h expected 1/2/22", rf_we, rf_waddr, rf_wdata); else passes++;
    checks++; if (lq_count !== 2'd0) $display("[TB] FAIL ld_count_empty: got %0d expected 0", lq_count); else passes++;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    applyStimulus(1'b1, 5'd7, 32'hA0, 1'b1, 5'd3, 32'h33);
    #1;
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1)
      $display("[TB] FAIL st_start_ready: got alu=%0b ld=%0b expected 1/1", alu_ready, ld_ready); else passes++;
    @(negedge clk);
    checks++; if (rf_wdata !== 32'hA0 || lq_count !== 2'd1)
      $display("[TB] FAIL st_first: got data=%h count=%0d expected a0/1", rf_wdata, lq_count); else passes++;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      applyStimulus(1'b1, 5'd7, 32'(32'hA0 + i), 1'b0, '0, '0);
      #1;
      checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL st_alu_wins%0d: got %0b expected 1", i, alu_ready); else passes++;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'(32'hA0 + i) || lq_count !== 2'd1)
        $display("[TB] FAIL st_alu_write%0d: got we=%0b data=%h count=%0d", i, rf_we, rf_wdata, lq_count); else passes++;
    end
    applyStimulus(1'b1, 5'd7, 32'hAF, 1'b0, '0, '0);
    #1;
    checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL st_forced: got alu_ready=%0b expected 0", alu_ready); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33 || lq_count !== 2'd0)
      $display("[TB] FAIL st_load_write: got we=%0b rd=%0d data=%h count=%0d expected 1/3/33/0",
               rf_we, rf_waddr, rf_wdata, lq_count); else passes++;
    applyStimulus(1'b1, 5'd7, 32'hB0, 1'b0, '0, '0);
    #1;
    checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL st_resume: got %0b expected 1", alu_ready); else passes++;
    @(negedge clk);
    checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'hB0)
      $display("[TB] FAIL st_resume_write: got rd=%0d data=%h expected 7/b0", rf_waddr, rf_wdata); else passes++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_full_queue();
    applyStimulus(1'b1, 5'd9, 32'h1, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 32'h2, 1'b1, 5'd6, 32'h66);
    #1;
    checks++; if (ld_ready !== 1'b1) $display("[TB] FAIL fq_ready1: got %0b expected 1", ld_ready); else passes++;
    @(negedge clk);
    checks++; if (lq_count !== 2'd2) $display("[TB] FAIL fq_count2: got %0d expected 2", lq_count); else passes++;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd8, 32'h88);
    #1;
    checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL fq_full_ready: got %0b expected 0", ld_ready); else passes++;
    @(negedge clk);
    idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44 || lq_count !== 2'd1)
      $display("[TB] FAIL fq_pop1: got we=%0b rd=%0d data=%h count=%0d expected 1/4/44/1",
               rf_we, rf_waddr, rf_wdata, lq_count); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66 || lq_count !== 2'd0)
      $display("[TB] FAIL fq_pop2: got we=%0b rd=%0d data=%h count=%0d expected 1/6/66/0",
               rf_we, rf_waddr, rf_wdata, lq_count); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL fq_refused_load: got we=%0b expected 0", rf_we); else passes++;
  endtask

  task automatic test_x0();
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h55);
    #1;
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1)
      $display("[TB] FAIL x0_ready: got alu=%0b ld=%0b expected 1/1", alu_ready, ld_ready); else passes++;
    @(negedge clk);
    idle();
    checks++; if (rf_we !== 1'b0 || lq_count !== 2'd1)
      $display("[TB] FAIL x0_alu: got we=%0b count=%0d expected 0/1", rf_we, lq_count); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || lq_count !== 2'd0)
      $display("[TB] FAIL x0_load: got we=%0b count=%0d expected 0/0", rf_we, lq_count); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 5'd9, 32'h1, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 32'h2, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    checks++; if (lq_count !== 2'd2 || rf_we !== 1'b1)
      $display("[TB] FAIL rm_prefill: got count=%0d we=%0b expected 2/1", lq_count, rf_we); else passes++;
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd9, 32'h3, 1'b1, 5'd8, 32'h88);
    #1;
    checks++; if (rf_we !== 1'b0 || lq_count !== 2'd0 || rf_waddr !== 5'd0)
      $display("[TB] FAIL rm_clear: got we=%0b count=%0d rd=%0d expected 0/0/0", rf_we, lq_count, rf_waddr); else passes++;
    checks++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0)
      $display("[TB] FAIL rm_ready: got alu=%0b ld=%0b expected 0/0", alu_ready, ld_ready); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || lq_count !== 2'd0)
      $display("[TB] FAIL rm_stale1: got we=%0b count=%0d expected 0/0", rf_we, lq_count); else passes++;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("[TB] FAIL rm_stale2: got we=%0b expected 0", rf_we); else passes++;
  endtask

  task automatic test_random();
    ld_t  e;
    int   sz, head, pop, last_pop;
    logic ea, el, aw, lw;
    do_reset();
    mq.delete(); sb_ld.delete(); sb_alu.delete();
    m_loss = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; last_pop = -1;
    for (int n = 0; n < 1012; n++) begin
      if (n < 1000)
        applyStimulus($urandom_range(0, 99) < 65,
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom() & 32'h7FFFFFFF,
                      $urandom_range(0, 99) < 50,
                      5'($urandom_range(1, 31)),
                      $urandom() | 32'h80000000);
      else
        idle();
      #1;
      sz = mq.size();
      ea = !(sz != 0 && m_loss == STARVE_MAX);
      el = (sz < LQ_DEPTH);
      checks++; if (alu_ready !== ea) $display("[TB] FAIL rnd_alu_ready@%0d: got %0b expected %0b", cyc, alu_ready, ea); else passes++;
      checks++; if (ld_ready !== el) $display("[TB] FAIL rnd_ld_ready@%0d: got %0b expected %0b", cyc, ld_ready, el); else passes++;
      if (alu_valid && alu_ready && alu_rd != 5'd0) begin
        e = '{rd: alu_rd, data: alu_data, acc: cyc};
        sb_alu.push_back(e);
      end
      if (ld_valid && ld_ready) begin
        e = '{rd: ld_rd, data: ld_data, acc: cyc};
        sb_ld.push_back(e);
      end
      aw = alu_valid && ea;
      lw = (sz != 0) && !aw;
      if (aw) begin
        m_we = (alu_rd != 5'd0); m_waddr = alu_rd; m_wdata = alu_data;
      end else if (lw) begin
        e = mq.pop_front();
        m_we = (e.rd != 5'd0); m_waddr = e.rd; m_wdata = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (sz == 0 || lw) m_loss = 0;
      else if (m_loss < STARVE_MAX) m_loss++;
      if (ld_valid && el) begin
        e = '{rd: ld_rd, data: ld_data, acc: cyc};
        mq.push_back(e);
      end
      @(negedge clk);
      checks++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata)
        $display("[TB] FAIL rnd_write@%0d: got we=%0b rd=%0d data=%h expected %0b/%0d/%h",
                 cyc, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); else passes++;
      checks++; if (lq_count !== CW'(mq.size()))
        $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", cyc, lq_count, mq.size()); else passes++;
      if (rf_we === 1'b1) begin
        if (rf_wdata[WW-1]) begin
          checks++;
          if (sb_ld.size() == 0) $display("[TB] FAIL rnd_ld_extra@%0d: got rd=%0d expected no load write", cyc, rf_waddr);
          else begin
            e = sb_ld.pop_front();
            if (e.rd !== rf_waddr || e.data !== rf_wdata)
              $display("[TB] FAIL rnd_ld_order@%0d: got %0d/%h expected %0d/%h", cyc, rf_waddr, rf_wdata, e.rd, e.data);
            else passes++;
            pop  = cyc - 1;
            head = (e.acc + 1 > last_pop + 1) ? e.acc + 1 : last_pop + 1;
            last_pop = pop;
            checks++; if (pop - head + 1 > STARVE_MAX + 1)
              $display("[TB] FAIL rnd_ld_wait@%0d: got %0d cycles at head expected <= %0d", cyc, pop - head + 1, STARVE_MAX + 1);
            else passes++;
          end
        end else begin
          checks++;
          if (sb_alu.size() == 0) $display("[TB] FAIL rnd_alu_extra@%0d: got rd=%0d expected no ALU write", cyc, rf_waddr);
          else begin
            e = sb_alu.pop_front();
            if (e.rd !== rf_waddr || e.data !== rf_wdata)
              $display("[TB] FAIL rnd_alu_match@%0d: got %0d/%h expected %0d/%h", cyc, rf_waddr, rf_wdata, e.rd, e.data);
            else passes++;
          end
        end
      end
    end
    checks++; if (sb_alu.size() != 0) $display("[TB] FAIL rnd_alu_lost: got %0d unwritten expected 0", sb_alu.size()); else passes++;
    checks++; if (sb_ld.size() != 0) $display("[TB] FAIL rnd_ld_lost: got %0d unwritten expected 0", sb_ld.size()); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    $display("[TB] starting wb_arbiter bench");
    test_reset();
    test_alu();
    test_loads();
    test_starvation();
    test_full_queue();
    test_x0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
